// File: rtl/bsg_circ_ptr_wrap.sv
// rtl/bsg_circ_ptr_wrap.sv - circular pointer register with explicit wrap at els_p-1
module bsg_circ_ptr_wrap #(
  parameter int els_p       = 2,
  parameter int ptr_width_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   incr_i,
  output logic [ptr_width_p-1:0] ptr_o
);

  // Last legal slot; compared explicitly so non-power-of-two depths wrap correctly.
  localparam logic [ptr_width_p-1:0] c_last = ptr_width_p'(els_p - 1);

  logic [ptr_width_p-1:0] r_ptr;

  // Advance by one on each event, returning to slot 0 after the last slot.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
    end else if (incr_i) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + ptr_width_p'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/bsg_bypass_skid_fifo.sv
// rtl/bsg_bypass_skid_fifo.sv - ready/valid elastic buffer with zero-latency bypass when empty
module bsg_bypass_skid_fifo #(
  parameter int width_p = 32,
  parameter int els_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int c_ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int c_cnt_w = $clog2(els_p + 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(els_p);

  logic [c_cnt_w-1:0] r_count;
  logic [width_p-1:0] r_mem [els_p];

  logic               w_empty;
  logic               w_enq;
  logic               w_write;
  logic               w_read;
  logic [c_ptr_w-1:0] w_rptr;
  logic [c_ptr_w-1:0] w_wptr;

  // ready depends only on stored state, never on yumi_i.
  assign w_empty = (r_count == '0);
  assign ready_o = (r_count != c_full);
  assign w_enq   = v_i & ready_o;

  // A word that is consumed the same cycle it arrives on an empty buffer is never stored.
  assign w_write = w_enq & ~(w_empty & yumi_i);
  assign w_read  = yumi_i & ~w_empty;

  // Bypass only while empty, so a live input can never overtake a stored word.
  assign v_o     = w_empty ? v_i    : 1'b1;
  assign data_o  = w_empty ? data_i : r_mem[w_rptr];
  assign count_o = r_count;

  bsg_circ_ptr_wrap #(
    .els_p       (els_p),
    .ptr_width_p (c_ptr_w)
  ) u_rptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (w_read),
    .ptr_o     (w_rptr)
  );

  bsg_circ_ptr_wrap #(
    .els_p       (els_p),
    .ptr_width_p (c_ptr_w)
  ) u_wptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (w_write),
    .ptr_o     (w_wptr)
  );

  // Occupancy tracks writes minus reads; simultaneous write and read leave it unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else begin
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only entries between rptr and wptr are ever observed.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[w_wptr] <= data_i;
    end
  end

endmodule

// File: tb/tb_bsg_bypass_skid_fifo.sv
// tb/tb_bsg_bypass_skid_fifo.sv - directed self-checking bench for bsg_bypass_skid_fifo
module tb_bsg_bypass_skid_fifo;

  logic        clk;
  logic        rst_n;

  logic        a_v_i, a_ready, a_v_o, a_yumi;
  logic [31:0] a_data_i, a_data_o;
  logic [1:0]  a_count;

  logic        b_v_i, b_ready, b_v_o, b_yumi;
  logic [31:0] b_data_i, b_data_o;
  logic [1:0]  b_count;

  int n_cmp  = 0;
  int n_fail = 0;

  bsg_circ_dummy_unused_guard u_guard_none ();

  bsg_bypass_skid_fifo #(.width_p(32), .els_p(2)) u_dut_a (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .v_i       (a_v_i),
    .data_i    (a_data_i),
    .ready_o   (a_ready),
    .v_o       (a_v_o),
    .data_o    (a_data_o),
    .yumi_i    (a_yumi),
    .count_o   (a_count)
  );

  bsg_bypass_skid_fifo #(.width_p(32), .els_p(3)) u_dut_b (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .v_i       (b_v_i),
    .data_i    (b_data_i),
    .ready_o   (b_ready),
    .v_o       (b_v_o),
    .data_o    (b_data_o),
    .yumi_i    (b_yumi),
    .count_o   (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic y);
    a_v_i    = v;
    a_data_i = d;
    a_yumi   = y;
    #1;
  endtask

  // Protocol monitors: consumer must never take a word that is not offered.
  always @(negedge clk) begin
    if (a_yumi && !a_v_o) begin
      n_fail++;
      $error("FAIL a_yumi_without_v_o observed=1 expected=0");
    end
    if (b_yumi && !b_v_o) begin
      n_fail++;
      $error("FAIL b_yumi_without_v_o observed=1 expected=0");
    end
    if (!rst_n && (a_yumi || b_yumi)) begin
      n_fail++;
      $error("FAIL yumi_in_reset observed=1 expected=0");
    end
    if (a_count > 2'd2 || b_count > 2'd3) begin
      n_fail++;
      $error("FAIL count_overflow observed=%0d/%0d expected<=2/3", a_count, b_count);
    end
  end

  initial begin
    int sent;
    int got;
    int cyc;
    logic tog;

    rst_n    = 1'b0;
    a_v_i    = 1'b0; a_data_i = '0; a_yumi = 1'b0;
    b_v_i    = 1'b0; b_data_i = '0; b_yumi = 1'b0;
    #2;
    chk("rst_count", {30'd0, a_count}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_v_o_idle", {31'd0, a_v_o}, 32'd0);
    drive_a(1'b1, 32'hCAFE_0000, 1'b0);
    chk("rst_v_o_bypass", {31'd0, a_v_o}, 32'd1);
    chk("rst_data_bypass", a_data_o, 32'hCAFE_0000);
    drive_a(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: bypass with same-cycle consume
    drive_a(1'b1, 32'hA5A5_0001, 1'b1);
    chk("t1_v_o", {31'd0, a_v_o}, 32'd1);
    chk("t1_data_o", a_data_o, 32'hA5A5_0001);
    tick();
    chk("t1_count", {30'd0, a_count}, 32'd0);

    // 2: stall and fill, ignored third push, drain in order
    drive_a(1'b1, 32'h11, 1'b0);
    tick();
    chk("t2_count1", {30'd0, a_count}, 32'd1);
    chk("t2_ready1", {31'd0, a_ready}, 32'd1);
    drive_a(1'b1, 32'h22, 1'b0);
    tick();
    chk("t2_count2", {30'd0, a_count}, 32'd2);
    chk("t2_ready_full", {31'd0, a_ready}, 32'd0);
    drive_a(1'b1, 32'h33, 1'b0);
    tick();
    chk("t2_count_ignored", {30'd0, a_count}, 32'd2);
    drive_a(1'b0, 32'h0, 1'b1);
    chk("t2_pop1", a_data_o, 32'h11);
    tick();
    chk("t2_pop2", a_data_o, 32'h22);
    chk("t2_count_after1", {30'd0, a_count}, 32'd1);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    chk("t2_count_empty", {30'd0, a_count}, 32'd0);
    chk("t2_v_o_empty", {31'd0, a_v_o}, 32'd0);

    // 3: full with simultaneous pop; incoming word refused
    drive_a(1'b1, 32'h11, 1'b0);
    tick();
    drive_a(1'b1, 32'h22, 1'b0);
    tick();
    drive_a(1'b1, 32'h33, 1'b1);
    chk("t3_ready_full", {31'd0, a_ready}, 32'd0);
    chk("t3_pop", a_data_o, 32'h11);
    tick();
    chk("t3_count", {30'd0, a_count}, 32'd1);
    chk("t3_ready_next", {31'd0, a_ready}, 32'd1);
    drive_a(1'b0, 32'h0, 1'b1);
    chk("t3_next_data", a_data_o, 32'h22);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    chk("t3_count_empty", {30'd0, a_count}, 32'd0);

    // 5: simultaneous enq/deq while holding one word
    drive_a(1'b1, 32'hAA, 1'b0);
    tick();
    drive_a(1'b1, 32'hBB, 1'b1);
    chk("t5_data_aa", a_data_o, 32'hAA);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    chk("t5_count", {30'd0, a_count}, 32'd1);
    chk("t5_data_bb", a_data_o, 32'hBB);
    drive_a(1'b0, 32'h0, 1'b1);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    chk("t5_count_empty", {30'd0, a_count}, 32'd0);

    // 4: els_p=3 streaming with alternating consume; order must be exact
    sent = 0;
    got  = 0;
    tog  = 1'b1;
    cyc  = 0;
    while (got < 10 && cyc < 100) begin
      b_v_i    = (sent < 10);
      b_data_i = sent;
      #1;
      b_yumi = tog & b_v_o;
      #1;
      if (b_yumi) begin
        chk($sformatf("t4_word%0d", got), b_data_o, got);
        got++;
      end
      if (b_v_i && b_ready) sent++;
      tick();
      b_yumi = 1'b0;
      tog = ~tog;
      cyc++;
    end
    b_v_i = 1'b0;
    chk("t4_words_out", got, 32'd10);
    chk("t4_count_end", {30'd0, b_count}, 32'd0);

    // 6: asynchronous reset between edges with two stored words
    drive_a(1'b1, 32'h44, 1'b0);
    tick();
    drive_a(1'b1, 32'h45, 1'b0);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    chk("t6_count_before", {30'd0, a_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_count_async", {30'd0, a_count}, 32'd0);
    chk("t6_ready_async", {31'd0, a_ready}, 32'd1);
    drive_a(1'b1, 32'h77, 1'b0);
    chk("t6_bypass_in_reset", a_data_o, 32'h77);
    drive_a(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();
    drive_a(1'b1, 32'h55, 1'b1);
    chk("t6_v_o_after", {31'd0, a_v_o}, 32'd1);
    chk("t6_data_after", a_data_o, 32'h55);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    chk("t6_count_after", {30'd0, a_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

module bsg_circ_dummy_unused_guard;
endmodule

// File: doc/bsg_bypass_skid_fifo.md
Name: bsg_bypass_skid_fifo

Overview:
- Ready/valid elastic buffer with a zero-latency bypass.
- When the buffer is empty, input data flows combinationally to the output, the same way an enabled bypass register passes data_i through.
- When the consumer stalls, the word is captured into an els_p-deep circular store and replayed in order.
- Sits on the producer side of pipeline boundaries.
- Lets a source fire without waiting a cycle, while guaranteeing no loss under backpressure.

Parameters:
- width_p, 32, data word width in bits.
- els_p, 2, storage entries; must be >= 1; need not be a power of two.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  upstream valid.
- data_i  in  width_p  upstream data.
- ready_o  out  1  buffer can accept a word this cycle.
- v_o  out  1  downstream valid.
- data_o  out  width_p  downstream data.
- yumi_i  in  1  downstream consumes the word this cycle; legal only when v_o=1.
- count_o  out  $clog2(els_p+1)  number of stored entries.

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset_n_i is asynchronous and active-low.
- Reset (reset_n_i=0, asynchronous):
  - rptr, wptr and count are cleared to 0.
  - Storage contents are don't-care.
  - ready_o=1 is held during reset.
  - v_o follows v_i through the bypass path even during reset. The consumer must not assert yumi_i while reset_n_i=0; a bench assertion flags it.
- Reset mid-operation discards all stored entries immediately; it does not wait for the clock.
- ready_o = (count != els_p). It is registered-state-only, with no combinational path from yumi_i.
- Accept: enq = v_i & ready_o.
- Empty state (count=0):
  - v_o=v_i, data_o=data_i (combinational bypass, zero latency).
  - If yumi_i=1 in the same cycle, nothing is written.
  - If v_i=1 and yumi_i=0, data_i is written at wptr.
- Non-empty state (count>0):
  - v_o=1, data_o=mem[rptr].
  - deq=yumi_i.
  - An enq writes mem[wptr], even in the same cycle as a deq.
- Write condition: enq & ~(count==0 & yumi_i).
- Read condition: yumi_i & (count!=0).
- Pointer update: each pointer increments by 1 on its event. At els_p-1 it wraps to 0 explicitly, with no reliance on power-of-two overflow.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, and on bypass.
- Full (count=els_p): ready_o=0; v_i is ignored, so no write and no pointer move. A simultaneous yumi_i drains one entry; ready_o rises the next cycle.
- Ordering: words emerge strictly in acceptance order. Bypass never overtakes a stored word, because bypass is enabled only when count=0.
- Latency: 0 cycles when empty and the consumer is ready; otherwise 1 + number of entries ahead.
- Illegal-use assertions (simulation only):
  - yumi_i while v_o=0.
  - count exceeding els_p.

Decomposition:
- No shared package is needed; the only derived constant is the pointer width, $clog2(els_p) (minimum 1).
- One sub-module, bsg_circ_ptr_wrap: a pointer register with asynchronous active-low reset, an increment enable, and explicit wrap at els_p-1. It is instanced twice, once for rptr and once for wptr.
- Storage is a flat register array written on posedge.
- The output mux selects data_i when count=0, else mem[rptr].

Test Plan:
1. Bypass: count=0, v_i=1, data_i=32'hA5A5_0001, yumi_i=1 in the same cycle -> v_o=1 and data_o=32'hA5A5_0001 that cycle; count_o stays 0.
2. Stall and fill (els_p=2): push 32'h11 then 32'h22 with yumi_i=0 -> count_o goes 1 then 2; ready_o=0. A third push of 32'h33 is ignored. Pop twice -> outputs 32'h11 then 32'h22; count_o returns to 0.
3. Full with simultaneous pop: count=2, v_i=1 (32'h33), yumi_i=1 -> 32'h11 is popped, 32'h33 is not accepted, count_o=1, ready_o=1 next cycle.
4. Wrap with els_p=3 (non-power-of-two): stream 10 words 32'h0..32'h9 with yumi_i toggling 1/0 -> output order is 0..9, exact; pointers wrap 2->0; no loss or duplication.
5. Simultaneous enq/deq while non-empty: count=1 holding 32'hAA, push 32'hBB and yumi_i=1 -> data_o=32'hAA that cycle, count_o stays 1, next data_o=32'hBB.
6. Asynchronous reset mid-stream: count=2, drop reset_n_i between clock edges -> count_o=0 and ready_o=1 immediately. After release, v_o follows v_i through the bypass path.
